// File: rtl/link_tx_sched_pkg.sv
// link_tx_sched_pkg: shared link-layer TX scheduler state encoding and default timing constants
package link_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GNT_TO,
        ST_GNT_LT,
        ST_GAP
    } tx_state_e;

    localparam int DEF_IPG_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_STARVE_MAX     = 4;

    function automatic logic is_gnt(tx_state_e s);
        return (s == ST_GNT_TO) || (s == ST_GNT_LT);
    endfunction

endpackage

// File: rtl/link_tx_watchdog.sv
// link_tx_watchdog: beat-cleared stall counter that strobes expiry after TIMEOUT_CYCLES idle cycles
module link_tx_watchdog
    import link_tx_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic beat_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero while inactive, so each new grant starts counting from zero
    always_comb begin
        cnt_d    = (!active_i || beat_i) ? '0 : cnt_q + 1'b1;
        expire_o = active_i && !beat_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/link_tx_sched.sv
// link_tx_sched: arbitrates token/handshake vs data packets onto the TX mux with IPG and stall abort
module link_tx_sched
    import link_tx_sched_pkg::*;
#(
    parameter int IPG_CYCLES     = DEF_IPG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int STARVE_MAX     = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic to_req_i,
    input  logic lt_req_i,
    output logic to_gnt_o,
    output logic lt_gnt_o,
    output logic tx_data_on_o,
    input  logic tx_lp_beat_i,
    input  logic tx_lp_eop_en_i,
    output logic busy_o,
    output logic tx_timeout_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int GW = $clog2(IPG_CYCLES + 2);

    tx_state_e     state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          to_gnt_q, lt_gnt_q, tx_data_on_q, busy_q, tx_timeout_q;
    logic          timeout_d, in_gnt, expire;

    assign in_gnt = is_gnt(state_q);

    link_tx_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active_i(in_gnt),
        .beat_i  (tx_lp_beat_i),
        .expire_o(expire)
    );

    // Arbitration, packet hold and gap sequencing; EOP takes precedence over watchdog expiry
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lt_req_i && (!to_req_i || starve_q == SW'(STARVE_MAX))) begin
                    state_d  = ST_GNT_LT;
                    starve_d = '0;
                end else if (to_req_i) begin
                    state_d  = ST_GNT_TO;
                    starve_d = lt_req_i ? starve_q + 1'b1 : '0;
                end else begin
                    starve_d = '0;
                end
            end
            ST_GNT_TO, ST_GNT_LT: begin
                if (tx_lp_eop_en_i || expire) begin
                    state_d   = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    gap_d     = '0;
                    timeout_d = !tx_lp_eop_en_i;
                end
            end
            ST_GAP: begin
                gap_d   = gap_q + 1'b1;
                state_d = (gap_q == GW'(IPG_CYCLES - 1)) ? ST_IDLE : ST_GAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            starve_q     <= '0;
            gap_q        <= '0;
            to_gnt_q     <= 1'b0;
            lt_gnt_q     <= 1'b0;
            tx_data_on_q <= 1'b0;
            busy_q       <= 1'b0;
            tx_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            gap_q        <= gap_d;
            to_gnt_q     <= state_d == ST_GNT_TO;
            lt_gnt_q     <= state_d == ST_GNT_LT;
            tx_data_on_q <= state_d == ST_GNT_LT;
            busy_q       <= state_d != ST_IDLE;
            tx_timeout_q <= timeout_d;
        end
    end

    assign to_gnt_o     = to_gnt_q;
    assign lt_gnt_o     = lt_gnt_q;
    assign tx_data_on_o = tx_data_on_q;
    assign busy_o       = busy_q;
    assign tx_timeout_o = tx_timeout_q;

endmodule

// File: tb/tb_link_tx_sched.sv
// tb_link_tx_sched: directed checks of arbitration, starvation, gap, watchdog and async reset
module tb_link_tx_sched;

    logic clk = 1'b0, rst_n = 1'b0;
    logic to_req = 1'b0, lt_req = 1'b0, beat = 1'b0, eop = 1'b0;
    logic to_gnt, lt_gnt, data_on, busy, tmo;
    logic [4:0] obs;
    int n_tests = 0, n_fail = 0;

    // obs = {to_gnt, lt_gnt, tx_data_on, busy, tx_timeout}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_TO   = 5'b10010;
    localparam logic [4:0] O_LT   = 5'b01110;
    localparam logic [4:0] O_GAP  = 5'b00010;
    localparam logic [4:0] O_TMO  = 5'b00011;

    assign obs = {to_gnt, lt_gnt, data_on, busy, tmo};

    link_tx_sched #(
        .IPG_CYCLES    (2),
        .TIMEOUT_CYCLES(16),
        .STARVE_MAX    (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .to_req_i      (to_req),
        .lt_req_i      (lt_req),
        .to_gnt_o      (to_gnt),
        .lt_gnt_o      (lt_gnt),
        .tx_data_on_o  (data_on),
        .tx_lp_beat_i  (beat),
        .tx_lp_eop_en_i(eop),
        .busy_o        (busy),
        .tx_timeout_o  (tmo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (obs[4:3] == 2'b00 && n < 8) begin
            step();
            n++;
        end
        chk("t3_wait", {3'b000, obs[4:3] != 2'b00, 1'b0}, 5'b00010);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("reset", obs, O_IDLE);
        rst_n = 1'b1;
        step();
        chk("post_reset", obs, O_IDLE);

        // single token/handshake packet
        to_req = 1'b1;
        chk("t1_latency", obs, O_IDLE);
        step();
        chk("t1_grant", obs, O_TO);
        to_req = 1'b0;
        beat   = 1'b1;
        step();
        step();
        chk("t1_hold", obs, O_TO);
        eop = 1'b1;
        step();
        eop  = 1'b0;
        beat = 1'b0;
        chk("t1_drop", obs, O_GAP);
        step();
        chk("t1_gap", obs, O_GAP);
        step();
        chk("t1_idle", obs, O_IDLE);

        // single data packet, five beats then EOP
        lt_req = 1'b1;
        step();
        lt_req = 1'b0;
        chk("t2_grant", obs, O_LT);
        beat = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_beat", obs, O_LT);
        end
        eop = 1'b1;
        step();
        eop  = 1'b0;
        beat = 1'b0;
        chk("t2_drop", obs, O_GAP);
        step();
        step();
        chk("t2_idle", obs, O_IDLE);

        // both requesters held: four TO grants then one forced LT, repeating
        to_req = 1'b1;
        lt_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_gnt();
            chk("t3_order", obs, (i % 5 == 4) ? O_LT : O_TO);
            eop  = 1'b1;
            beat = 1'b1;
            step();
            eop  = 1'b0;
            beat = 1'b0;
        end
        to_req = 1'b0;
        lt_req = 1'b0;
        step();
        step();
        chk("t3_idle", obs, O_IDLE);

        // stalled data packet aborted by watchdog, pending TO then granted
        lt_req = 1'b1;
        step();
        chk("t4_grant", obs, O_LT);
        lt_req = 1'b0;
        to_req = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("t4_hold", obs, O_LT);
        end
        step();
        chk("t4_timeout", obs, O_TMO);
        step();
        chk("t4_pulse_end", obs, O_GAP);
        step();
        chk("t4_gap_end", obs, O_IDLE);
        step();
        chk("t4_to_grant", obs, O_TO);
        to_req = 1'b0;
        eop    = 1'b1;
        beat   = 1'b1;
        step();
        eop  = 1'b0;
        beat = 1'b0;
        step();
        step();
        chk("t4_idle", obs, O_IDLE);

        // EOP in the same cycle as watchdog expiry wins
        to_req = 1'b1;
        step();
        chk("t5_grant", obs, O_TO);
        to_req = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("t5_hold", obs, O_TO);
        end
        eop = 1'b1;
        step();
        eop = 1'b0;
        chk("t5_no_timeout", obs, O_GAP);
        step();
        chk("t5_gap", obs, O_GAP);
        step();
        chk("t5_idle", obs, O_IDLE);

        // asynchronous reset mid data packet
        lt_req = 1'b1;
        step();
        chk("t6_grant", obs, O_LT);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", obs, O_IDLE);
        step();
        rst_n = 1'b1;
        chk("t6_release", obs, O_IDLE);
        step();
        chk("t6_regrant", obs, O_LT);
        lt_req = 1'b0;
        eop    = 1'b1;
        step();
        eop = 1'b0;
        chk("t6_drop", obs, O_GAP);
        step();
        step();
        chk("t6_idle", obs, O_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
